rf_wb_arbiter: RTL and testbench

//  Owns the single write port of the register file (Regfiles: we/waddr/wdata).

---
 rtl/rfarb_pkg.sv | 19 +
 rtl/rf_wb_arbiter_if.sv | 26 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/rf_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rfarb_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
// Optional forwarding is enabled by defining RFARB_FWD_EN (see rf_wb_arbiter).
package rfarb_pkg;

    localparam int RFARB_DATA_W = 32;
    localparam int RFARB_ADDR_W = 5;
    localparam int RFARB_NREGS  = 32;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus: one valid/ready channel per requester (ALU and MEM).
// A transfer happens on a rising clk edge where valid && ready. valid never depends
// on ready, and addr/data stay stable from valid rising until the transfer.
interface rf_wb_arbiter_if #(
    parameter int ADDR_W = rfarb_pkg::RFARB_ADDR_W,
    parameter int DATA_W = rfarb_pkg::RFARB_DATA_W
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    modport master (
        output a_valid, a_addr, a_data, m_valid, m_addr, m_data,
        input  a_ready, m_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data, m_valid, m_addr, m_data,
        output a_ready, m_ready
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational; the caller owns the prio register.
// On a tie the requester named by prio wins; a lone requester always wins.
module rr_arb2
    import rfarb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (prio == REQ_MEM) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Owns the register-file write port: round-robin ALU/MEM writeback plus a bulk clear sweep.
// Define RFARB_FWD_EN to add write-to-read forwarding hit detection (fwd_raddrN/fwd_hitN).
module rf_wb_arbiter
    import rfarb_pkg::*;
#(
    parameter int DATA_W      = RFARB_DATA_W,
    parameter int ADDR_W      = RFARB_ADDR_W,
    parameter int NREGS       = RFARB_NREGS,
    parameter bit ZERO_REG_RO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    rf_wb_arbiter_if.slave    wb,
    input  logic              clr_req,
    output logic              busy,
    output logic              grant_m,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output state_e            state
`ifdef RFARB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] fwd_raddr1,
    input  logic [ADDR_W-1:0] fwd_raddr2,
    output logic              fwd_hit1,
    output logic              fwd_hit2
`endif
);

    // Explicit compare against the last index so the sweep end never depends on idx wrapping.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    req_id_e           prio_q, prio_d;
    logic              grant_m_q, grant_m_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        gnt;
    logic              a_rdy, m_rdy;

    rr_arb2 u_arb (
        .req  ({wb.m_valid, wb.a_valid}),
        .prio (prio_q),
        .gnt  (gnt)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        prio_d    = prio_q;
        grant_m_d = grant_m_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        a_rdy     = 1'b0;
        m_rdy     = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = FIRST_IDX;
                end else begin
                    a_rdy = gnt[REQ_ALU];
                    m_rdy = gnt[REQ_MEM];
                    if (m_rdy) begin
                        we_d      = !(ZERO_REG_RO && (wb.m_addr == '0));
                        waddr_d   = wb.m_addr;
                        wdata_d   = wb.m_data;
                        grant_m_d = 1'b1;
                        prio_d    = REQ_ALU;
                    end else if (a_rdy) begin
                        we_d      = !(ZERO_REG_RO && (wb.a_addr == '0));
                        waddr_d   = wb.a_addr;
                        wdata_d   = wb.a_data;
                        grant_m_d = 1'b0;
                        prio_d    = REQ_MEM;
                    end
                end
            end
            ST_CLEAR: begin
                we_d    = 1'b1;
                waddr_d = idx_q;
                wdata_d = '0;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            idx_q     <= '0;
            prio_q    <= REQ_ALU;
            grant_m_q <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            prio_q    <= prio_d;
            grant_m_q <= grant_m_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign wb.a_ready = a_rdy;
    assign wb.m_ready = m_rdy;
    assign busy       = (state_q == ST_CLEAR);
    assign grant_m    = grant_m_q;
    assign rf_we      = we_q;
    assign rf_waddr   = waddr_q;
    assign rf_wdata   = wdata_q;
    assign state      = state_q;

`ifdef RFARB_FWD_EN
    // A hit means the consumer must take rf_wdata; x0 is never forwarded.
    assign fwd_hit1 = we_q && (waddr_q == fwd_raddr1) && (waddr_q != '0);
    assign fwd_hit2 = we_q && (waddr_q == fwd_raddr2) && (waddr_q != '0);
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter with a register file behind it; directed tests plus a
// per-cycle comparison against a queue-based behavioural model.
module tb_rf_wb_arbiter;
    import rfarb_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr_req;
    logic              busy, grant_m, rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    state_e            state;
`ifdef RFARB_FWD_EN
    logic [ADDR_W-1:0] fwd_raddr1, fwd_raddr2;
    logic              fwd_hit1, fwd_hit2;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    bit run_chk = 1'b0;
    logic rf_clr;

    rf_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb ();

    rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .ZERO_REG_RO(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb       (wb),
        .clr_req  (clr_req),
        .busy     (busy),
        .grant_m  (grant_m),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .state    (state)
`ifdef RFARB_FWD_EN
        ,
        .fwd_raddr1 (fwd_raddr1),
        .fwd_raddr2 (fwd_raddr2),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2)
`endif
    );

    always #5 clk = ~clk;

    // Register file sitting behind the arbiter; not touched by the arbiter reset.
    logic [DATA_W-1:0] rf_mem [NREGS];
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < NREGS; i++) rf_mem[i] <= '0;
        end else if (rf_we) begin
            rf_mem[rf_waddr] <= rf_wdata;
        end
    end

    function automatic logic [DATA_W-1:0] rd(input int a);
        return (a == 0) ? '0 : rf_mem[a];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: a pending sweep is a queue of addresses still to be zeroed.
    logic [ADDR_W-1:0] sweep_q[$];
    logic [DATA_W-1:0] exp_rf [NREGS];
    logic              exp_we, exp_gm, mem_next;
    logic [ADDR_W-1:0] exp_waddr;
    logic [DATA_W-1:0] exp_wdata;

    function automatic logic [1:0] model_gnt();
        if (rst || sweep_q.size() != 0 || clr_req) return 2'b00;
        if (wb.a_valid && wb.m_valid) return mem_next ? 2'b10 : 2'b01;
        return {wb.m_valid, wb.a_valid};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rf_clr) begin
            for (int i = 0; i < NREGS; i++) exp_rf[i] <= '0;
        end else if (!rst && exp_we) begin
            exp_rf[exp_waddr] <= exp_wdata;
        end
        if (rst) begin
            sweep_q.delete();
            mem_next  <= 1'b0;
            exp_we    <= 1'b0;
            exp_waddr <= '0;
            exp_wdata <= '0;
            exp_gm    <= 1'b0;
        end else if (sweep_q.size() != 0) begin
            exp_we    <= 1'b1;
            exp_waddr <= sweep_q.pop_front();
            exp_wdata <= '0;
        end else if (clr_req) begin
            for (int i = 1; i < NREGS; i++) sweep_q.push_back(ADDR_W'(i));
            exp_we <= 1'b0;
        end else begin
            case (model_gnt())
                2'b01: begin
                    exp_we    <= (wb.a_addr != '0);
                    exp_waddr <= wb.a_addr;
                    exp_wdata <= wb.a_data;
                    exp_gm    <= 1'b0;
                    mem_next  <= 1'b1;
                end
                2'b10: begin
                    exp_we    <= (wb.m_addr != '0);
                    exp_waddr <= wb.m_addr;
                    exp_wdata <= wb.m_data;
                    exp_gm    <= 1'b1;
                    mem_next  <= 1'b0;
                end
                default: exp_we <= 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (run_chk && !rst) begin
            chk("m.a_ready", wb.a_ready, model_gnt() == 2'b01);
            chk("m.m_ready", wb.m_ready, model_gnt() == 2'b10);
            chk("m.rf_we", rf_we, exp_we);
            chk("m.rf_waddr", rf_waddr, exp_waddr);
            chk("m.rf_wdata", rf_wdata, exp_wdata);
            chk("m.busy", busy, sweep_q.size() != 0);
            chk("m.grant_m", grant_m, exp_gm);
            chk("m.state", state, (sweep_q.size() != 0) ? ST_CLEAR : ST_RUN);
`ifdef RFARB_FWD_EN
            chk("m.fwd_hit1", fwd_hit1, exp_we && exp_waddr == fwd_raddr1 && exp_waddr != '0);
            chk("m.fwd_hit2", fwd_hit2, exp_we && exp_waddr == fwd_raddr2 && exp_waddr != '0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    logic [DATA_W-1:0] fill_val [NREGS];

    task automatic fill();
        for (int i = 1; i < NREGS; i++) begin
            fill_val[i] = DATA_W'($urandom_range(1, 32'h7fff_ffff));
            wb.a_valid = 1'b1;
            wb.a_addr  = ADDR_W'(i);
            wb.a_data  = fill_val[i];
            tick();
        end
        wb.a_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        rf_clr = 1'b1;
        clr_req = 1'b0;
        wb.a_valid = 1'b0; wb.a_addr = '0; wb.a_data = '0;
        wb.m_valid = 1'b0; wb.m_addr = '0; wb.m_data = '0;
`ifdef RFARB_FWD_EN
        fwd_raddr1 = '0; fwd_raddr2 = '0;
`endif
        tick();
        rf_clr = 1'b0;
        do_reset();
        run_chk = 1'b1;

        // 1: reset values, single ALU write and read-back
        chk("rst.rf_we", rf_we, 1'b0);
        chk("rst.rf_waddr", rf_waddr, 0);
        chk("rst.rf_wdata", rf_wdata, 0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.grant_m", grant_m, 1'b0);
        chk("rst.state", state, ST_RUN);
        wb.a_valid = 1'b1; wb.a_addr = 5'd1; wb.a_data = 32'hA5A5A5A5;
        #1;
        chk("t1.a_ready", wb.a_ready, 1'b1);
        tick();
        chk("t1.rf_we", rf_we, 1'b1);
        chk("t1.rf_waddr", rf_waddr, 1);
        chk("t1.rf_wdata", rf_wdata, 32'hA5A5A5A5);
        wb.a_valid = 1'b0;
        tick();
        tick();
        chk("t1.r1", rd(1), 32'hA5A5A5A5);

        // 2: both valid after reset -> ALU first, then strict alternation
        do_reset();
        wb.a_valid = 1'b1; wb.a_addr = 5'd2; wb.a_data = 32'h11111111;
        wb.m_valid = 1'b1; wb.m_addr = 5'd3; wb.m_data = 32'h22222222;
        #1;
        chk("t2.a_ready0", wb.a_ready, 1'b1);
        chk("t2.m_ready0", wb.m_ready, 1'b0);
        tick();
        chk("t2.grant_m0", grant_m, 1'b0);
        chk("t2.waddr0", rf_waddr, 2);
        chk("t2.m_ready1", wb.m_ready, 1'b1);
        chk("t2.a_ready1", wb.a_ready, 1'b0);
        tick();
        chk("t2.grant_m1", grant_m, 1'b1);
        chk("t2.waddr1", rf_waddr, 3);
        chk("t2.wdata1", rf_wdata, 32'h22222222);
        for (int k = 0; k < 4; k++) begin
            chk("t2.alt_a_ready", wb.a_ready, (k % 2) == 0);
            tick();
            chk("t2.alt_grant_m", grant_m, (k % 2) == 1);
        end
        wb.a_valid = 1'b0;
        wb.m_valid = 1'b0;
        tick();
        tick();
        chk("t2.r2", rd(2), 32'h11111111);
        chk("t2.r3", rd(3), 32'h22222222);

        // 3: write to x0 is accepted but dropped
        wb.m_valid = 1'b1; wb.m_addr = 5'd0; wb.m_data = 32'hFFFFFFFF;
        #1;
        chk("t3.m_ready", wb.m_ready, 1'b1);
        tick();
        wb.m_valid = 1'b0;
        chk("t3.rf_we", rf_we, 1'b0);
        tick();
        chk("t3.r0_raw", rf_mem[0], 32'h0);

        // 4: clear sweep with both requesters waiting
        fill();
        chk("t4.r31_filled", rd(31), fill_val[31]);
        clr_req = 1'b1;
        wb.a_valid = 1'b1; wb.a_addr = 5'd7; wb.a_data = 32'h77;
        wb.m_valid = 1'b1; wb.m_addr = 5'd8; wb.m_data = 32'h88;
        #1;
        chk("t4.a_ready_clr", wb.a_ready, 1'b0);
        chk("t4.m_ready_clr", wb.m_ready, 1'b0);
        tick();
        clr_req = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            chk("t4.busy", busy, 1'b1);
            chk("t4.ready_q", {wb.a_ready, wb.m_ready}, 2'b00);
            tick();
            chk("t4.sweep_we", rf_we, 1'b1);
            chk("t4.sweep_addr", rf_waddr, i);
            chk("t4.sweep_data", rf_wdata, 0);
        end
        chk("t4.busy_done", busy, 1'b0);
        chk("t4.m_ready_after", wb.m_ready, 1'b1);
        tick();
        wb.m_valid = 1'b0;
        for (int i = 1; i < NREGS; i++) chk("t4.cleared", rd(i), 0);
        chk("t4.a_ready_after", wb.a_ready, 1'b1);
        tick();
        wb.a_valid = 1'b0;
        tick();
        tick();
        chk("t4.r7", rd(7), 32'h77);
        chk("t4.r8", rd(8), 32'h88);

        // 5: reset in the middle of a sweep
        fill();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        chk("t5.waddr10", rf_waddr, 10);
        chk("t5.busy_mid", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("t5.rst_we", rf_we, 1'b0);
        chk("t5.rst_waddr", rf_waddr, 0);
        chk("t5.rst_wdata", rf_wdata, 0);
        chk("t5.rst_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5.state", state, ST_RUN);
        chk("t5.busy", busy, 1'b0);
        for (int i = 1; i < 10; i++) chk("t5.low_cleared", rd(i), 0);
        for (int i = 11; i < NREGS; i++) chk("t5.high_kept", rd(i), fill_val[i]);

`ifdef RFARB_FWD_EN
        // 6: forwarding hit in the rf_we cycle
        wb.a_valid = 1'b1; wb.a_addr = 5'd4; wb.a_data = 32'hCAFEF00D;
        tick();
        wb.a_valid = 1'b0;
        fwd_raddr1 = 5'd4;
        fwd_raddr2 = 5'd5;
        #1;
        chk("t6.fwd_hit1", fwd_hit1, 1'b1);
        chk("t6.fwd_hit2", fwd_hit2, 1'b0);
        chk("t6.fwd_data", rf_wdata, 32'hCAFEF00D);
        tick();
        tick();
`endif

        tick();
        for (int i = 0; i < NREGS; i++) chk("final.rf_vs_model", rd(i), exp_rf[i]);
        run_chk = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
